// File: rtl/lfsr_rand_gen_pkg.sv
// Shared types and constants for the LFSR random source: step actions,
// recommended maximal-length tap masks (bit i set = state bit i feeds back) and seed sanitising.
package rng_pkg;

    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_LOAD,
        ACT_STEP,
        ACT_RECOVER
    } lfsr_act_e;

    localparam logic [2:0]  TAPS_W3  = 3'h6;
    localparam logic [3:0]  TAPS_W4  = 4'hC;
    localparam logic [4:0]  TAPS_W5  = 5'h14;
    localparam logic [5:0]  TAPS_W6  = 6'h30;
    localparam logic [6:0]  TAPS_W7  = 7'h60;
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [8:0]  TAPS_W9  = 9'h110;
    localparam logic [9:0]  TAPS_W10 = 10'h240;
    localparam logic [10:0] TAPS_W11 = 11'h500;
    localparam logic [11:0] TAPS_W12 = 12'h829;
    localparam logic [12:0] TAPS_W13 = 13'h100D;
    localparam logic [13:0] TAPS_W14 = 14'h2015;
    localparam logic [14:0] TAPS_W15 = 15'h6000;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [16:0] TAPS_W17 = 17'h12000;
    localparam logic [17:0] TAPS_W18 = 18'h20400;
    localparam logic [18:0] TAPS_W19 = 19'h40023;
    localparam logic [19:0] TAPS_W20 = 20'h90000;
    localparam logic [20:0] TAPS_W21 = 21'h140000;
    localparam logic [21:0] TAPS_W22 = 22'h300000;
    localparam logic [22:0] TAPS_W23 = 23'h420000;
    localparam logic [23:0] TAPS_W24 = 24'hE10000;
    localparam logic [24:0] TAPS_W25 = 25'h1200000;
    localparam logic [25:0] TAPS_W26 = 26'h2000023;
    localparam logic [26:0] TAPS_W27 = 27'h4000013;
    localparam logic [27:0] TAPS_W28 = 28'h9000000;
    localparam logic [28:0] TAPS_W29 = 29'h14000000;
    localparam logic [29:0] TAPS_W30 = 30'h20000029;
    localparam logic [30:0] TAPS_W31 = 31'h48000000;
    localparam logic [31:0] TAPS_W32 = 32'h80200003;

    // An all-zero LFSR never leaves zero, so zero seeds are replaced by 1.
    function automatic logic [31:0] nonzero_seed(input logic [31:0] s);
        return (s == '0) ? 32'd1 : s;
    endfunction

endpackage

// File: rtl/lfsr_rand_gen_if.sv
// Valid/ready sample stream between the random source (master) and its consumer (slave).
interface lfsr_rand_gen_if #(
    parameter int unsigned OUT_W = 4
);
    logic [OUT_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/lfsr_rand_gen_core.sv
// Fibonacci LFSR state register: reset to sanitised seed, runtime load, step on enable,
// and recovery from an all-zero state. Reports the action taken so the wrapper can gate draws.
module lfsr_core
    import rng_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] state,
    output lfsr_act_e        act
);

    localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(nonzero_seed(32'(SEED)));

    logic             fb;
    logic [WIDTH-1:0] next_state;

    assign fb         = ^(state & TAPS);
    assign next_state = {state[WIDTH-2:0], fb};

    always_comb begin
        act = ACT_HOLD;
        if (load) begin
            act = ACT_LOAD;
        end else if (en) begin
            act = (state == '0) ? ACT_RECOVER : ACT_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RESET_VAL;
        end else begin
            case (act)
                ACT_LOAD:    state <= WIDTH'(nonzero_seed(32'(load_val)));
                ACT_STEP:    state <= next_state;
                ACT_RECOVER: state <= WIDTH'(1);
                default:     state <= state;
            endcase
        end
    end

endmodule

// File: rtl/lfsr_rand_gen.sv
// Range-limited pseudo-random sample stream built on lfsr_core, using rejection sampling
// and valid/ready back-pressure. Define RNG_REJECT_CNT_EN to add the reject_cnt port.
module lfsr_rand_gen
    import rng_pkg::*;
#(
    parameter int unsigned      WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
    parameter int unsigned      OUT_W = 4,
    parameter int unsigned      RANGE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 seed_load,
    input  logic [WIDTH-1:0]     seed_in,
    lfsr_rand_gen_if.master      stream,
    output logic                 lockup
`ifdef RNG_REJECT_CNT_EN
    ,
    output logic [15:0]          reject_cnt
`endif
);

    logic [WIDTH-1:0] state;
    lfsr_act_e        act;
    logic [OUT_W-1:0] cand;
    logic             in_range;
    logic             handshake;
    logic             slot_free;
    logic             draw;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .load     (seed_load),
        .load_val (seed_in),
        .state    (state),
        .act      (act)
    );

    // Candidate comes from the pre-advance state; the core steps in the same edge.
    assign cand = OUT_W'(state);

    generate
        if (64'(RANGE) >= (64'd1 << OUT_W)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_limited_range
            localparam logic [OUT_W-1:0] LIMIT = OUT_W'(RANGE);
            assign in_range = (cand < LIMIT);
        end
    endgenerate

    assign handshake = stream.out_valid && stream.out_ready;
    assign slot_free = !stream.out_valid || stream.out_ready;
    assign draw      = (act == ACT_STEP) && slot_free;

    always_ff @(posedge clk) begin
        if (rst) begin
            stream.out_valid <= 1'b0;
            stream.out_data  <= '0;
            lockup           <= 1'b0;
        end else begin
            lockup <= (act == ACT_RECOVER);
            if (draw && in_range) begin
                stream.out_data  <= cand;
                stream.out_valid <= 1'b1;
            end else if ((act == ACT_LOAD) || draw || handshake) begin
                stream.out_valid <= 1'b0;
            end
        end
    end

`ifdef RNG_REJECT_CNT_EN
    always_ff @(posedge clk) begin
        if (rst || (act == ACT_LOAD)) begin
            reject_cnt <= '0;
        end else if (draw && !in_range && (reject_cnt != '1)) begin
            reject_cnt <= reject_cnt + 16'd1;
        end
    end
`endif

endmodule
